// File: rtl/uart_tx_arbiter_if.sv
// Byte-stream bundle between NUM_REQ requesters, the arbiter and a shared uart_tx.
// The master side is the requester/uart_tx environment; the arbiter uses the slave side.
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ-1:0]   req_vld;
  logic [8*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]   req_last;
  logic [NUM_REQ-1:0]   req_rdy;
  logic                 tx_vld;
  logic [7:0]           tx_data;
  logic                 tx_rdy;
  logic [NUM_REQ-1:0]   grant;
  logic                 busy;
  logic                 pkt_abort;
  logic                 pkt_trunc;

  modport master (
    output req_vld, req_data, req_last, tx_rdy,
    input  req_rdy, tx_vld, tx_data, grant, busy, pkt_abort, pkt_trunc
  );

  modport slave (
    input  req_vld, req_data, req_last, tx_rdy,
    output req_rdy, tx_vld, tx_data, grant, busy, pkt_abort, pkt_trunc
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Packet-granular round-robin arbiter sharing one uart_tx among NUM_REQ byte streams,
// with byte-count and stall watchdogs that force the grant free.
module uart_tx_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int MAX_PKT_LEN = 64,
  parameter int STALL_CYC   = 1024
) (
  input  logic               clk,
  input  logic               rst,
  uart_tx_arbiter_if.slave   bus
);
  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int BC_W  = $clog2(MAX_PKT_LEN + 1);
  localparam int SC_W  = $clog2(STALL_CYC + 1);

  typedef enum logic {IDLE = 1'b0, XFER = 1'b1} state_e;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] owner_q, owner_d;
  logic [IDX_W-1:0] rr_q, rr_d;
  logic [BC_W-1:0]  byte_cnt_q, byte_cnt_d;
  logic [SC_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic             abort_q, abort_d;
  logic             trunc_q, trunc_d;
  logic             own_vld, own_last, xfer;

  // First requesting index strictly after the last owner, wrapping around.
  function automatic logic [IDX_W-1:0] pick_next(input logic [IDX_W-1:0] rr,
                                                 input logic [NUM_REQ-1:0] vld);
    logic [IDX_W-1:0] sel;
    logic             found;
    int               idx;
    sel   = rr;
    found = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(rr) + k) % NUM_REQ;
      if (!found && vld[idx]) begin
        sel   = IDX_W'(idx);
        found = 1'b1;
      end
    end
    return sel;
  endfunction

  always_comb begin
    own_vld  = bus.req_vld[owner_q];
    own_last = bus.req_last[owner_q];
    xfer     = (state_q == XFER) && own_vld && bus.tx_rdy;
  end

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    rr_d        = rr_q;
    byte_cnt_d  = byte_cnt_q;
    stall_cnt_d = stall_cnt_q;
    abort_d     = 1'b0;
    trunc_d     = 1'b0;
    bus.tx_vld  = 1'b0;
    bus.tx_data = 8'h00;
    bus.req_rdy = '0;
    case (state_q)
      IDLE: begin
        if (|bus.req_vld) begin
          owner_d     = pick_next(rr_q, bus.req_vld);
          byte_cnt_d  = '0;
          stall_cnt_d = '0;
          state_d     = XFER;
        end
      end
      XFER: begin
        bus.tx_vld           = own_vld;
        bus.tx_data          = bus.req_data[{owner_q, 3'b000} +: 8];
        bus.req_rdy[owner_q] = bus.tx_rdy;
        if (xfer) begin
          byte_cnt_d  = byte_cnt_q + 1'b1;
          stall_cnt_d = '0;
          if (own_last) begin
            state_d = IDLE;
          end else if (byte_cnt_d == BC_W'(MAX_PKT_LEN)) begin
            state_d = IDLE;
            trunc_d = 1'b1;
          end
        end else if (!own_vld) begin
          // Backpressure with a byte waiting holds the counter; only an absent byte counts.
          stall_cnt_d = stall_cnt_q + 1'b1;
          if (stall_cnt_d == SC_W'(STALL_CYC)) begin
            state_d = IDLE;
            abort_d = 1'b1;
          end
        end
        if (state_d == IDLE) rr_d = owner_q;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      owner_q     <= '0;
      rr_q        <= IDX_W'(NUM_REQ - 1);
      byte_cnt_q  <= '0;
      stall_cnt_q <= '0;
      abort_q     <= 1'b0;
      trunc_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      rr_q        <= rr_d;
      byte_cnt_q  <= byte_cnt_d;
      stall_cnt_q <= stall_cnt_d;
      abort_q     <= abort_d;
      trunc_q     <= trunc_d;
    end
  end

  assign bus.busy      = (state_q == XFER);
  assign bus.grant     = (state_q == XFER) ? (NUM_REQ'(1) << owner_q) : '0;
  assign bus.pkt_abort = abort_q;
  assign bus.pkt_trunc = trunc_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: cycle vector table, directed packet scenarios and
// random traffic, all compared against a behavioural arbitration model.
module tb_uart_tx_arbiter;
  localparam int N     = 4;
  localparam int MAXL  = 64;
  localparam int STALL = 1024;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  uart_tx_arbiter_if #(.NUM_REQ(N)) bus();
  uart_tx_arbiter #(.NUM_REQ(N), .MAX_PKT_LEN(MAXL), .STALL_CYC(STALL))
    dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic        rst;
    logic [3:0]  vld;
    logic [31:0] data;
    logic [3:0]  last;
    logic        rdy;
    logic        chk;
    logic [3:0]  e_grant;
    logic        e_busy;
    logic        e_txv;
    logic [7:0]  e_txd;
    logic [3:0]  e_rdy;
  } vec_t;
  localparam int NV = 12;
  vec_t vt [NV];

  int checks = 0, errors = 0, cyc = 0;
  logic [8:0] pq [N][$];
  logic [N-1:0] en;
  bit agents_on = 1'b0, rdy_tgl = 1'b0;
  int rdy_mode = 0;

  int m_owner, m_rr, m_bytes, m_stall;
  bit m_abort, m_trunc, m_known = 1'b0;

  int gq[$];
  logic [7:0] txq[$];
  int abort_cnt, trunc_cnt, abort_cyc, trunc_cyc, last_tx_cyc, pulse_tx_cyc, tx_at_pulse;
  logic [N-1:0] pulse_grant;
  bit prev_busy = 1'b0;
  logic [N-1:0] snap_grant, snap_rdy;
  logic snap_busy, snap_txv, snap_abort, snap_trunc;
  logic [7:0] snap_txd;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  // Expected outputs follow directly from who owns the link and the live inputs.
  task automatic model_check();
    logic [N-1:0] e_grant, e_rdy;
    logic e_busy, e_txv;
    logic [7:0] e_txd;
    if (!m_known) return;
    e_busy = (m_owner >= 0);
    e_grant = '0; e_rdy = '0; e_txv = 1'b0; e_txd = 8'h00;
    if (e_busy) begin
      e_grant[m_owner] = 1'b1;
      e_rdy[m_owner]   = bus.tx_rdy;
      e_txv            = bus.req_vld[m_owner];
      e_txd            = bus.req_data[8*m_owner +: 8];
    end
    chk("model ctl",
        32'({bus.grant, bus.busy, bus.tx_vld, bus.req_rdy, bus.pkt_abort, bus.pkt_trunc}),
        32'({e_grant, e_busy, e_txv, e_rdy, m_abort, m_trunc}));
    if (e_txv) chk("model data", 32'(bus.tx_data), 32'(e_txd));
  endtask

  task automatic model_release();
    m_rr = m_owner;
    m_owner = -1;
  endtask

  task automatic model_step();
    bit found;
    int c;
    if (rst) begin
      m_known = 1'b1; m_owner = -1; m_rr = N - 1;
      m_bytes = 0; m_stall = 0; m_abort = 1'b0; m_trunc = 1'b0;
      return;
    end
    m_abort = 1'b0; m_trunc = 1'b0;
    if (m_owner < 0) begin
      found = 1'b0;
      for (int k = 1; k <= N; k++) begin
        c = (m_rr + k) % N;
        if (!found && bus.req_vld[c]) begin
          m_owner = c; found = 1'b1;
        end
      end
      m_bytes = 0; m_stall = 0;
    end else if (bus.req_vld[m_owner] && bus.tx_rdy) begin
      m_bytes++; m_stall = 0;
      if (bus.req_last[m_owner]) model_release();
      else if (m_bytes == MAXL) begin m_trunc = 1'b1; model_release(); end
    end else if (!bus.req_vld[m_owner]) begin
      m_stall++;
      if (m_stall == STALL) begin m_abort = 1'b1; model_release(); end
    end
  endtask

  task automatic drive();
    logic [8:0] h;
    case (rdy_mode)
      0: bus.tx_rdy = 1'b1;
      1: begin rdy_tgl = ~rdy_tgl; bus.tx_rdy = rdy_tgl; end
      default: bus.tx_rdy = ($urandom_range(0, 3) != 0);
    endcase
    for (int i = 0; i < N; i++) begin
      if (pq[i].size() > 0 && en[i]) begin
        h = pq[i][0];
        bus.req_vld[i] = 1'b1;
        bus.req_data[8*i +: 8] = h[7:0];
        bus.req_last[i] = h[8];
      end else begin
        bus.req_vld[i] = 1'b0;
        bus.req_data[8*i +: 8] = 8'($urandom);
        bus.req_last[i] = 1'($urandom);
      end
    end
  endtask

  task automatic cycle();
    logic [N-1:0] acc;
    @(negedge clk);
    model_check();
    acc = bus.req_vld & bus.req_rdy;
    if (bus.busy && !prev_busy)
      for (int i = 0; i < N; i++) if (bus.grant[i]) gq.push_back(i);
    prev_busy = bus.busy;
    if (bus.tx_vld && bus.tx_rdy) begin txq.push_back(bus.tx_data); last_tx_cyc = cyc; end
    if (bus.pkt_abort || bus.pkt_trunc) begin
      pulse_tx_cyc = last_tx_cyc; tx_at_pulse = txq.size(); pulse_grant = bus.grant;
    end
    if (bus.pkt_abort) begin abort_cnt++; abort_cyc = cyc; end
    if (bus.pkt_trunc) begin trunc_cnt++; trunc_cyc = cyc; end
    snap_grant = bus.grant; snap_busy = bus.busy; snap_txv = bus.tx_vld;
    snap_txd = bus.tx_data; snap_rdy = bus.req_rdy;
    snap_abort = bus.pkt_abort; snap_trunc = bus.pkt_trunc;
    @(posedge clk);
    model_step();
    #1;
    cyc++;
    if (agents_on) begin
      for (int i = 0; i < N; i++) if (acc[i] && pq[i].size() > 0) void'(pq[i].pop_front());
      drive();
    end
  endtask

  task automatic clear_logs();
    gq.delete(); txq.delete();
    abort_cnt = 0; trunc_cnt = 0; abort_cyc = 0; trunc_cyc = 0;
    last_tx_cyc = 0; pulse_tx_cyc = 0; tx_at_pulse = 0; pulse_grant = '0;
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    for (int i = 0; i < N; i++) pq[i].delete();
    en = '1;
    cycle(); cycle();
    rst = 1'b0;
    clear_logs();
  endtask

  task automatic run_until_grants(input int n, input int budget);
    for (int t = 0; t < budget && gq.size() < n; t++) cycle();
  endtask

  initial begin
    int mism;
    vt[0]  = '{1'b1, 4'b0000, 32'h00000000, 4'b0000, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b0, 8'h00, 4'b0000};
    vt[1]  = '{1'b0, 4'b0001, 32'h000000A1, 4'b0000, 1'b1, 1'b1, 4'b0000, 1'b0, 1'b0, 8'h00, 4'b0000};
    vt[2]  = '{1'b0, 4'b1011, 32'h330011A1, 4'b0000, 1'b1, 1'b1, 4'b0001, 1'b1, 1'b1, 8'hA1, 4'b0001};
    vt[3]  = '{1'b0, 4'b1011, 32'h330011A2, 4'b0000, 1'b0, 1'b1, 4'b0001, 1'b1, 1'b1, 8'hA2, 4'b0000};
    vt[4]  = '{1'b0, 4'b1011, 32'h330011A2, 4'b0000, 1'b1, 1'b1, 4'b0001, 1'b1, 1'b1, 8'hA2, 4'b0001};
    vt[5]  = '{1'b0, 4'b1011, 32'h330011A3, 4'b0001, 1'b1, 1'b1, 4'b0001, 1'b1, 1'b1, 8'hA3, 4'b0001};
    vt[6]  = '{1'b0, 4'b1010, 32'h3300B100, 4'b0010, 1'b1, 1'b1, 4'b0000, 1'b0, 1'b0, 8'h00, 4'b0000};
    vt[7]  = '{1'b0, 4'b1010, 32'h3300B100, 4'b0010, 1'b1, 1'b1, 4'b0010, 1'b1, 1'b1, 8'hB1, 4'b0010};
    vt[8]  = '{1'b0, 4'b1000, 32'hC1000000, 4'b1000, 1'b1, 1'b1, 4'b0000, 1'b0, 1'b0, 8'h00, 4'b0000};
    vt[9]  = '{1'b0, 4'b1000, 32'hC1000000, 4'b1000, 1'b1, 1'b1, 4'b1000, 1'b1, 1'b1, 8'hC1, 4'b1000};
    vt[10] = '{1'b0, 4'b0000, 32'h00000000, 4'b1111, 1'b1, 1'b1, 4'b0000, 1'b0, 1'b0, 8'h00, 4'b0000};
    vt[11] = '{1'b0, 4'b0000, 32'h00000000, 4'b1111, 1'b1, 1'b1, 4'b0000, 1'b0, 1'b0, 8'h00, 4'b0000};
    clear_logs();

    for (int r = 0; r < NV; r++) begin
      rst = vt[r].rst;
      bus.req_vld = vt[r].vld; bus.req_data = vt[r].data;
      bus.req_last = vt[r].last; bus.tx_rdy = vt[r].rdy;
      cycle();
      if (vt[r].chk) begin
        chk($sformatf("vec%0d ctl", r),
            32'({snap_grant, snap_busy, snap_txv, snap_rdy, snap_abort, snap_trunc}),
            32'({vt[r].e_grant, vt[r].e_busy, vt[r].e_txv, vt[r].e_rdy, 2'b00}));
        if (vt[r].e_txv) chk($sformatf("vec%0d data", r), 32'(snap_txd), 32'(vt[r].e_txd));
      end
    end

    // All four requesters hold two 2-byte packets each.
    agents_on = 1'b1; rdy_mode = 0;
    reset_dut();
    for (int i = 0; i < N; i++)
      for (int p = 0; p < 2; p++)
        for (int b = 0; b < 2; b++) pq[i].push_back({b == 1, 8'((i << 4) | (p << 1) | b)});
    for (int t = 0; t < 200 && txq.size() < 10; t++) cycle();
    chk("rr grant count", 32'(gq.size() >= 5), 32'(1));
    for (int k = 0; k < 5; k++)
      if (k < gq.size()) chk($sformatf("rr grant %0d", k), 32'(gq[k]), 32'(k % 4));
    chk("rr byte count", 32'(txq.size() >= 10), 32'(1));
    for (int k = 0; k < 10; k++)
      if (k < txq.size())
        chk($sformatf("rr byte %0d", k), 32'(txq[k]),
            32'((((k / 2) % 4) << 4) | ((k / 8) << 1) | (k % 2)));

    // Long backpressured run from requester 2 must never trip the stall watchdog.
    reset_dut(); rdy_mode = 1;
    begin
      logic [7:0] eb[$];
      for (int p = 0; p < 35; p++)
        for (int b = 0; b < 60; b++) begin
          pq[2].push_back({b == 59, 8'(p * 7 + b * 13)});
          eb.push_back(8'(p * 7 + b * 13));
        end
      for (int t = 0; t < 5000; t++) cycle();
      chk("bp no abort", 32'(abort_cnt), 32'(0));
      chk("bp no trunc", 32'(trunc_cnt), 32'(0));
      chk("bp byte total", 32'(txq.size()), 32'(eb.size()));
      mism = 0;
      for (int k = 0; k < eb.size() && k < txq.size(); k++) if (txq[k] !== eb[k]) mism++;
      chk("bp byte order", 32'(mism), 32'(0));
    end

    // Requester 1 goes silent mid-packet while 3 waits.
    reset_dut(); rdy_mode = 0;
    pq[1].push_back({1'b0, 8'h5A});
    pq[3].push_back({1'b1, 8'h3C});
    run_until_grants(2, STALL + 200);
    chk("stall abort count", 32'(abort_cnt), 32'(1));
    chk("stall abort delay", 32'(abort_cyc - pulse_tx_cyc), 32'(STALL + 1));
    chk("stall grant cleared", 32'(pulse_grant), 32'(0));
    chk("stall first owner", 32'(gq.size() > 0 ? gq[0] : -1), 32'(1));
    chk("stall next owner", 32'(gq.size() > 1 ? gq[1] : -1), 32'(3));

    // Requester 0 streams 70 bytes without a last flag.
    reset_dut();
    for (int b = 0; b < 70; b++) pq[0].push_back({1'b0, 8'(b)});
    pq[1].push_back({1'b1, 8'hEE});
    run_until_grants(2, 300);
    chk("trunc count", 32'(trunc_cnt), 32'(1));
    chk("trunc bytes", 32'(tx_at_pulse), 32'(MAXL));
    chk("trunc delay", 32'(trunc_cyc - pulse_tx_cyc), 32'(1));
    chk("trunc next owner", 32'(gq.size() > 1 ? gq[1] : -1), 32'(1));

    // Last flag on exactly byte MAXL is a normal end.
    reset_dut();
    for (int b = 0; b < MAXL; b++) pq[0].push_back({b == MAXL - 1, 8'(b)});
    pq[1].push_back({1'b1, 8'hEE});
    run_until_grants(2, 300);
    chk("full len no trunc", 32'(trunc_cnt), 32'(0));
    chk("full len next owner", 32'(gq.size() > 1 ? gq[1] : -1), 32'(1));
    chk("full len bytes", 32'(txq.size() >= MAXL), 32'(1));

    // Reset lands on byte 2 of requester 2's packet after requester 1 has been served.
    reset_dut();
    pq[1].push_back({1'b1, 8'h11});
    for (int b = 0; b < 4; b++) pq[2].push_back({b == 3, 8'(8'h20 + b)});
    for (int t = 0; t < 50 && txq.size() < 2; t++) cycle();
    chk("mid rst setup", 32'(txq.size()), 32'(2));
    rst = 1'b1;
    for (int i = 0; i < N; i++) pq[i].delete();
    pq[0].push_back({1'b1, 8'hA0});
    pq[3].push_back({1'b1, 8'hD3});
    cycle();
    rst = 1'b0;
    cycle();
    chk("mid rst idle", 32'({snap_grant, snap_busy, snap_txv}), 32'(0));
    cycle();
    chk("mid rst tie", 32'(snap_grant), 32'(4'b0001));

    // Random traffic, stalls, truncations and backpressure against the model.
    reset_dut(); rdy_mode = 2;
    for (int t = 0; t < 4000; t++) begin
      cycle();
      if ($urandom_range(0, 19) == 0) begin
        int r, len;
        bit has_last;
        r = $urandom_range(0, N - 1);
        len = $urandom_range(1, 70);
        has_last = ($urandom_range(0, 99) < 85);
        for (int b = 0; b < len; b++)
          pq[r].push_back({has_last && (b == len - 1), 8'($urandom)});
      end
      for (int i = 0; i < N; i++) en[i] = ($urandom_range(0, 19) != 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
